// File: rtl/adc_sample_capture.sv
// Latches DB_18 LATCH_DLY edges after RD_18 falls into a 2^ADDR_W FWFT FIFO; head visible the edge after the push.
// Backpressure: m_ready pops the head; a capture arriving on a full FIFO with no pop is dropped and flagged.
module adc_sample_capture #(
    parameter int DATA_W    = 12,
    parameter int ADDR_W    = 4,
    parameter int LATCH_DLY = 4
) (
    input  logic              clk_100M,
    input  logic              Reset,
    input  logic              RD_18,
    input  logic [DATA_W-1:0] DB_18,
    input  logic              enable,
    input  logic              clear_flags,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic              rd_short,
    output logic [31:0]       sample_cnt
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(LATCH_DLY + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PUSH, S_HOLD} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              rd_prev;
    logic              fall, capture, short_err;
    logic [DATA_W-1:0] cap;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic              full, push, pop, drop;

    assign fall = rd_prev & ~RD_18;

    always_ff @(posedge clk_100M) begin
        if (Reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        short_err = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (fall && enable) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            // The latch edge itself samples the bus regardless of RD; only earlier rises abort.
            S_WAIT: begin
                if (cnt == CNT_W'(LATCH_DLY)) begin
                    capture   = 1'b1;
                    state_nxt = S_PUSH;
                end else if (RD_18) begin
                    short_err = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_PUSH: state_nxt = S_HOLD;
            S_HOLD: begin
                if (RD_18) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A pop in the push cycle frees the slot, so a full FIFO still accepts the word.
    assign full       = (count == (ADDR_W + 1)'(DEPTH));
    assign m_valid    = (count != '0);
    assign pop        = m_valid & m_ready;
    assign push       = (state == S_PUSH) & (~full | pop);
    assign drop       = (state == S_PUSH) & full & ~pop;
    assign m_data     = m_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

    always_ff @(posedge clk_100M) begin
        if (Reset) begin
            rd_prev    <= 1'b0;
            cap        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            rd_short   <= 1'b0;
            sample_cnt <= '0;
        end else begin
            rd_prev <= RD_18;
            if (capture) cap <= DB_18;
            if (push) begin
                wr_ptr     <= wr_ptr + ADDR_W'(1);
                sample_cnt <= sample_cnt + 32'd1;
            end
            if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
            count <= count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
            if (drop)             overflow <= 1'b1;
            else if (clear_flags) overflow <= 1'b0;
            if (short_err)        rd_short <= 1'b1;
            else if (clear_flags) rd_short <= 1'b0;
        end
    end

    always_ff @(posedge clk_100M) begin
        if (push) mem[wr_ptr] <= cap;
    end

endmodule

// File: tb/tb_adc_sample_capture.sv
// Scoreboarded bench for adc_sample_capture: expected words queued as conversions are driven, checked as drained.
module tb_adc_sample_capture;
    localparam int DW = 12;
    localparam int AW = 4;

    logic          clk_100M = 1'b0;
    logic          Reset, RD_18, enable, clear_flags, m_ready;
    logic [DW-1:0] DB_18, m_data;
    logic          m_valid, overflow, rd_short;
    logic [AW:0]   fifo_count;
    logic [31:0]   sample_cnt;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] sb[$];
    int            exp_samples = 0;

    always #5 clk_100M = ~clk_100M;

    adc_sample_capture #(.DATA_W(DW), .ADDR_W(AW), .LATCH_DLY(4)) dut (
        .clk_100M(clk_100M), .Reset(Reset), .RD_18(RD_18), .DB_18(DB_18),
        .enable(enable), .clear_flags(clear_flags), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .fifo_count(fifo_count),
        .overflow(overflow), .rd_short(rd_short), .sample_cnt(sample_cnt)
    );

    // Bench model of one completed conversion arriving at the FIFO with no pop.
    task automatic model_push(input logic [DW-1:0] w);
        if (sb.size() < 16) begin
            sb.push_back(w);
            exp_samples++;
        end
    endtask

    // RD low for 'low' edges starting at E0; DB switches d0 -> d1 just after edge E0+k.
    task automatic conv(input int low, input logic [DW-1:0] d0, input logic [DW-1:0] d1, input int k);
        @(posedge clk_100M); #1;
        RD_18 = 1'b0;
        DB_18 = d0;
        for (int e = 0; e < low; e++) begin
            @(posedge clk_100M); #1;
            if (e == k) DB_18 = d1;
        end
        RD_18 = 1'b1;
        repeat (2) @(posedge clk_100M);
        #1;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(posedge clk_100M); #1;
        clear_flags = 1'b0;
    endtask

    task automatic drain();
        logic [DW-1:0] exp;
        m_ready = 1'b1;
        for (int i = 0; i < 40 && m_valid; i++) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL drain_extra: got %h, required no word", m_data);
            end else begin
                exp = sb.pop_front();
                if (m_data !== exp) begin
                    errors++;
                    $display("FAIL drain_data: got %h, required %h", m_data, exp);
                end
            end
            @(posedge clk_100M); #1;
        end
        m_ready = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_missing: %0d words never appeared, required 0", sb.size());
        end
        checks++;
        if (fifo_count !== 0) begin
            errors++;
            $display("FAIL drain_count: got %0d, required 0", fifo_count);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; RD_18 = 1'b1; DB_18 = '0; enable = 1'b1;
        clear_flags = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk_100M);
        #1;
        checks++;
        if ({m_valid, overflow, rd_short} !== 3'b000 || m_data !== '0) begin
            errors++;
            $display("FAIL reset_out: got v=%b ovf=%b sh=%b d=%h, required 0", m_valid, overflow, rd_short, m_data);
        end
        checks++;
        if (fifo_count !== 0 || sample_cnt !== 0) begin
            errors++;
            $display("FAIL reset_cnt: got cnt=%0d smp=%0d, required 0", fifo_count, sample_cnt);
        end
        Reset = 1'b0;
        repeat (2) @(posedge clk_100M);
        #1;
    endtask

    task automatic test_single();
        @(posedge clk_100M); #1;
        RD_18 = 1'b0;
        DB_18 = 12'hA5C;
        repeat (5) @(posedge clk_100M);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: m_valid got %b after E0+4, required 0", m_valid);
        end
        @(posedge clk_100M); #1;
        model_push(12'hA5C);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 12'hA5C) begin
            errors++;
            $display("FAIL single_head: got v=%b d=%h, required v=1 d=a5c", m_valid, m_data);
        end
        RD_18 = 1'b1;
        repeat (2) @(posedge clk_100M);
        #1;
        checks++;
        if (fifo_count !== 1 || sample_cnt !== 32'(exp_samples)) begin
            errors++;
            $display("FAIL single_cnt: got cnt=%0d smp=%0d, required 1/%0d", fifo_count, sample_cnt, exp_samples);
        end
        drain();
    endtask

    task automatic test_latch();
        conv(6, 12'h111, 12'h222, 3);
        model_push(12'h222);
        conv(6, 12'h111, 12'h222, 4);
        model_push(12'h111);
        checks++;
        if (fifo_count !== 2) begin
            errors++;
            $display("FAIL latch_cnt: got %0d, required 2", fifo_count);
        end
        drain();
    endtask

    task automatic test_short();
        conv(2, 12'h3C3, 12'h3C3, 99);
        checks++;
        if (rd_short !== 1'b1 || fifo_count !== 0 || sample_cnt !== 32'(exp_samples)) begin
            errors++;
            $display("FAIL short_flag: got sh=%b cnt=%0d smp=%0d, required 1/0/%0d", rd_short, fifo_count, sample_cnt, exp_samples);
        end
        conv(6, 12'h5A5, 12'h5A5, 99);
        model_push(12'h5A5);
        checks++;
        if (fifo_count !== 1) begin
            errors++;
            $display("FAIL short_next: got cnt=%0d, required 1", fifo_count);
        end
        drain();
        pulse_clear();
        checks++;
        if (rd_short !== 1'b0) begin
            errors++;
            $display("FAIL short_clear: got %b, required 0", rd_short);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) begin
            conv(6, 12'(12'h100 + i), 12'(12'h100 + i), 99);
            model_push(12'(12'h100 + i));
        end
        checks++;
        if (fifo_count !== 16 || overflow !== 1'b1 || sample_cnt !== 32'(exp_samples)) begin
            errors++;
            $display("FAIL ovf_state: got cnt=%0d ovf=%b smp=%0d, required 16/1/%0d", fifo_count, overflow, sample_cnt, exp_samples);
        end
        drain();
        pulse_clear();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b, required 0", overflow);
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        conv(6, 12'h0EE, 12'h0EE, 99);
        checks++;
        if (fifo_count !== 0 || sample_cnt !== 32'(exp_samples)) begin
            errors++;
            $display("FAIL en_block: got cnt=%0d smp=%0d, required 0/%0d", fifo_count, sample_cnt, exp_samples);
        end
        enable = 1'b1;
        @(posedge clk_100M); #1;
        RD_18 = 1'b0;
        DB_18 = 12'h777;
        @(posedge clk_100M); #1;
        enable = 1'b0;
        repeat (5) @(posedge clk_100M);
        #1;
        RD_18 = 1'b1;
        model_push(12'h777);
        repeat (2) @(posedge clk_100M);
        #1;
        enable = 1'b1;
        checks++;
        if (fifo_count !== 1) begin
            errors++;
            $display("FAIL en_mid: got cnt=%0d, required 1", fifo_count);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        conv(6, 12'h444, 12'h444, 99);
        model_push(12'h444);
        @(posedge clk_100M); #1;
        RD_18 = 1'b0;
        DB_18 = 12'h999;
        repeat (2) @(posedge clk_100M);
        #1;
        Reset = 1'b1;
        repeat (2) @(posedge clk_100M);
        #1;
        Reset = 1'b0;
        sb.delete();
        exp_samples = 0;
        repeat (4) @(posedge clk_100M);
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== '0 || fifo_count !== 0 || sample_cnt !== 0 || overflow !== 1'b0 || rd_short !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_out: got v=%b d=%h cnt=%0d smp=%0d, required all 0", m_valid, m_data, fifo_count, sample_cnt);
        end
        RD_18 = 1'b1;
        repeat (2) @(posedge clk_100M);
        #1;
        conv(6, 12'h6B6, 12'h6B6, 99);
        model_push(12'h6B6);
        checks++;
        if (sample_cnt !== 32'd1 || fifo_count !== 1) begin
            errors++;
            $display("FAIL rstmid_next: got smp=%0d cnt=%0d, required 1/1", sample_cnt, fifo_count);
        end
        drain();
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] head;
        for (int i = 0; i < 16; i++) begin
            conv(6, 12'(12'h200 + 3 * i), 12'(12'h200 + 3 * i), 99);
            model_push(12'(12'h200 + 3 * i));
        end
        @(posedge clk_100M); #1;
        RD_18 = 1'b0;
        DB_18 = 12'hF0F;
        repeat (5) @(posedge clk_100M);
        #1;
        head = sb.pop_front();
        checks++;
        if (m_data !== head || fifo_count !== 16) begin
            errors++;
            $display("FAIL fullpop_pre: got d=%h cnt=%0d, required %h/16", m_data, fifo_count, head);
        end
        m_ready = 1'b1;
        @(posedge clk_100M); #1;
        m_ready = 1'b0;
        RD_18 = 1'b1;
        sb.push_back(12'hF0F);
        exp_samples++;
        checks++;
        if (fifo_count !== 16 || overflow !== 1'b0 || sample_cnt !== 32'(exp_samples)) begin
            errors++;
            $display("FAIL fullpop_post: got cnt=%0d ovf=%b smp=%0d, required 16/0/%0d", fifo_count, overflow, sample_cnt, exp_samples);
        end
        repeat (2) @(posedge clk_100M);
        #1;
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_latch();
        test_short();
        test_overflow();
        test_enable();
        test_reset_mid();
        test_full_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_sample_capture.md
Name: adc_sample_capture

Overview:
- Downstream neighbour of the ADC control FSM on the 18-pin parallel ADC interface.
- Watches the RD_18 strobe produced by the control block and latches the ADC parallel data bus at a programmable delay after RD falls.
- Buffers samples in a first-word-fall-through FIFO and presents them on a valid/ready stream to the processing logic.
- Reports overflow, short-RD errors and an accepted-sample count.

Parameters:
- DATA_W, 12: ADC data bus width.
- ADDR_W, 4: FIFO address width; depth = 2^ADDR_W = 16 words.
- LATCH_DLY, 4: clock edges after RD fall detection at which DB_18 is sampled. Legal range 1..5 for a 6-cycle RD pulse.

Ports:
- clk_100M  in  1  System clock, 100 MHz. Sole clock.
- Reset  in  1  Synchronous, active-high reset.
- RD_18  in  1  Active-low read strobe from the ADC control block; same clock domain, so no synchroniser.
- DB_18  in  DATA_W  ADC parallel output data.
- enable  in  1  Allows new captures to start.
- clear_flags  in  1  One-cycle pulse; clears the sticky flags.
- m_data  out  DATA_W  FIFO head word.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  Consumer accepts the head word.
- fifo_count  out  ADDR_W+1  Words held, 0..16.
- overflow  out  1  Sticky: a sample was dropped because the FIFO was full.
- rd_short  out  1  Sticky: RD returned high before the latch point.
- sample_cnt  out  32  Accepted samples; wraps 0xFFFFFFFF -> 0.

Behaviour:
- Reset (checked at the clock edge, overrides all other logic):
  - State = IDLE; FIFO empty; fifo_count = 0; m_valid = 0; m_data = 0.
  - overflow = 0; rd_short = 0; sample_cnt = 0; delay counter = 0.
  - rd_prev = 0, so RD_18 already low at reset release is not treated as a fall. That partial read is ignored.
- Fall detection: the fall edge E0 is the first edge where rd_prev = 1 and RD_18 = 0. rd_prev <= RD_18 every cycle.
- IDLE: on E0 with enable = 1, go to WAIT and set cnt = 1. Otherwise stay in IDLE.
- WAIT:
  - If RD_18 = 1 at any edge before the latch point: set rd_short = 1, go to IDLE, write nothing.
  - Otherwise increment cnt each edge.
  - At edge E0+LATCH_DLY (cnt = LATCH_DLY): capture DB_18 into the capture register and go to PUSH.
- PUSH (one cycle), at edge E0+LATCH_DLY+1:
  - If FIFO not full: write the word and increment sample_cnt.
  - If full: drop the word, set overflow = 1, leave sample_cnt unchanged.
  - Then go to HOLD.
- HOLD: stay until RD_18 = 1, then go to IDLE. A new fall is accepted only after RD_18 has been observed high.
- enable deasserted mid-capture: the current capture completes normally; only new starts are blocked.
- Latency: a word written at edge E0+LATCH_DLY+1 into an empty FIFO shows m_valid = 1 and m_data = word after that same edge.
- FIFO:
  - Pop when m_valid && m_ready.
  - Push and pop in the same cycle: count unchanged, both occur. Pop while full frees the slot, so a simultaneous push succeeds without overflow.
  - Pop while empty is ignored.
  - Pointers wrap modulo 16. fifo_count is the exact occupancy.
  - m_data is held stable while m_valid = 1 and m_ready = 0.
- Flags: clear_flags clears overflow and rd_short. If a set and a clear occur in the same cycle, the set wins.
- No combinational path from any input to any output, except m_ready to the internal pop.

Test Plan:
- Single capture: DB_18 = 0xA5C, RD_18 low for 6 cycles starting after E0, enable = 1, m_ready = 0 -> m_valid rises after E0+5, m_data = 0xA5C, fifo_count = 1, sample_cnt = 1.
- Latch point: DB_18 changes 0x111 -> 0x222 at E0+4 (setup met), with 0x111 stable before -> captured word is 0x222. Repeat with LATCH_DLY = 2 and the change at E0+3 -> captured word is 0x111.
- Overflow: 17 conversions, m_ready = 0 -> fifo_count = 16, overflow = 1, sample_cnt = 16. Drain with m_ready = 1 -> words appear in write order. clear_flags -> overflow = 0.
- Short RD: RD_18 low for only 2 cycles -> rd_short = 1, fifo_count unchanged, FSM back in IDLE. The next full-length RD captures normally.
- Reset mid-operation: assert Reset at E0+2 while RD_18 is low, release while still low -> no word written, all outputs 0. The next full RD pulse is captured correctly.
- Full plus simultaneous pop: FIFO at 16 with m_ready = 1 in the PUSH cycle -> push accepted, count stays 16, overflow stays 0.
